// File: rtl/mips_cpu_hilo_muldiv.sv
// HI/LO owner with an iterative 32-step multiply/divide engine.
// Define MULDIV_FAST_MUL_EN for single-cycle MULT/MULTU.
module mips_cpu_hilo_muldiv #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        is_div_q, is_div_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        signed_op;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [32:0] div_r;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] div_step;
    logic [63:0] prod_fix;
`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fast_prod;
`endif

    // Datapath helpers: operand magnitudes and one engine step
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        a_mag     = (signed_op && a[31]) ? (32'd0 - a) : a;
        b_mag     = (signed_op && b[31]) ? (32'd0 - b) : b;
        mul_sum   = {1'b0, acc_q[63:32]}
                  + (acc_q[0] ? {1'b0, dvsr_q} : 33'd0);
        mul_step  = {mul_sum, acc_q[31:1]};
        div_r     = {acc_q[63:32], acc_q[31]};
        div_ge    = div_r >= {1'b0, dvsr_q};
        div_sub   = div_r[31:0] - dvsr_q;
        div_step  = {(div_ge ? div_sub : div_r[31:0]),
                     acc_q[30:0], div_ge};
        prod_fix  = negq_q ? (64'd0 - acc_q) : acc_q;
`ifdef MULDIV_FAST_MUL_EN
        if (signed_op)
            fast_prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        else
            fast_prod = {32'd0, a} * {32'd0, b};
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        dvsr_d   = dvsr_q;
        is_div_d = is_div_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
                            hi_d   = fast_prod[63:32];
                            lo_d   = fast_prod[31:0];
                            done_d = 1'b1;
`else
                            acc_d    = {32'd0, b_mag};
                            dvsr_d   = a_mag;
                            is_div_d = 1'b0;
                            negq_d   = signed_op & (a[31] ^ b[31]);
                            negr_d   = signed_op & a[31];
                            cnt_d    = 6'd0;
                            state_d  = RUN;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            is_div_d = 1'b1;
                            cnt_d    = 6'd0;
                            state_d  = RUN;
                            // Divide by zero leaves the raw dividend in HI
                            if (b == 32'd0) begin
                                acc_d  = {32'd0, a};
                                dvsr_d = 32'd0;
                                negq_d = 1'b0;
                                negr_d = 1'b0;
                            end else begin
                                acc_d  = {32'd0, a_mag};
                                dvsr_d = b_mag;
                                negq_d = signed_op & (a[31] ^ b[31]);
                                negr_d = signed_op & a[31];
                            end
                        end
                        OP_MTHI: begin
                            hi_d   = a;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                acc_d = is_div_q ? div_step : mul_step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(ITER - 1))
                    state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    lo_d = negq_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
                    hi_d = negr_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            acc_q    <= 64'd0;
            dvsr_q   <= 32'd0;
            is_div_q <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            dvsr_q   <= dvsr_d;
            is_div_q <= is_div_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_hilo_muldiv.sv
// Directed bench for mips_cpu_hilo_muldiv: MTHI/MTLO, mul/div,
// divide by zero, ignored starts and mid-operation reset.
module tb_mips_cpu_hilo_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk  = 0;
    int n_pass = 0;

    mips_cpu_hilo_muldiv #(.ITER(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
        op    = 3'd7;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el);
        logic [31:0] ph;
        logic [31:0] pl;
        int          lat;
        logic        bad;
        ph  = hi;
        pl  = lo;
        lat = 33;
`ifdef MULDIV_FAST_MUL_EN
        if (o <= 3'd1) lat = 1;
`endif
        issue(o, x, y);
        if (lat > 1) begin
            bad = 1'b0;
            for (int i = 0; i < lat; i++) begin
                if (busy !== 1'b1 || done !== 1'b0 ||
                    hi !== ph || lo !== pl)
                    bad = 1'b1;
                step();
            end
            chk({tag, " hold"}, 64'(bad), 64'(1'b0));
        end
        chk({tag, " done"}, 64'(done), 64'(1'b1));
        chk({tag, " busy"}, 64'(busy), 64'(1'b0));
        chk({tag, " hi"}, 64'(hi), 64'(eh));
        chk({tag, " lo"}, 64'(lo), 64'(el));
        step();
        chk({tag, " done_end"}, 64'(done), 64'(1'b0));
    endtask

    initial begin
        logic [31:0] ph;
        logic [31:0] pl;
        logic        bad;
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd7;
        a     = 32'd0;
        b     = 32'd0;
        step();
        step();
        chk("rst hi", 64'(hi), 64'd0);
        chk("rst lo", 64'(lo), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        reset = 1'b0;
        step();

        issue(3'd4, 32'h12345678, 32'd0);
        chk("mthi hi", 64'(hi), 64'h12345678);
        chk("mthi done", 64'(done), 64'd1);
        chk("mthi busy", 64'(busy), 64'd0);
        step();
        chk("mthi done_end", 64'(done), 64'd0);

        issue(3'd5, 32'h9ABCDEF0, 32'd0);
        chk("mtlo lo", 64'(lo), 64'h9ABCDEF0);
        chk("mtlo hi", 64'(hi), 64'h12345678);
        chk("mtlo done", 64'(done), 64'd1);
        step();

        ph = hi;
        pl = lo;
        issue(3'd6, 32'h55555555, 32'h1);
        chk("op6 done", 64'(done), 64'd0);
        chk("op6 busy", 64'(busy), 64'd0);
        chk("op6 hi", 64'(hi), 64'(ph));
        chk("op6 lo", 64'(lo), 64'(pl));

        run_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3,
               32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001);
        run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2,
               32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF,
               32'h0, 32'h80000000);
        run_op("divu0", 3'd3, 32'h55, 32'h0, 32'h55, 32'hFFFFFFFF);
        run_op("div0", 3'd2, 32'hFFFFFFF0, 32'h0,
               32'hFFFFFFF0, 32'hFFFFFFFF);

        ph  = hi;
        pl  = lo;
        bad = 1'b0;
        issue(3'd3, 32'd100, 32'd7);
        for (int i = 0; i < 33; i++) begin
            if (i == 5) begin
                start = 1'b1;
                op    = 3'd4;
                a     = 32'hDEADBEEF;
            end
            if (busy !== 1'b1 || done !== 1'b0 ||
                hi !== ph || lo !== pl)
                bad = 1'b1;
            step();
            start = 1'b0;
            op    = 3'd7;
        end
        chk("ign hold", 64'(bad), 64'd0);
        chk("ign done", 64'(done), 64'd1);
        chk("ign hi", 64'(hi), 64'd2);
        chk("ign lo", 64'(lo), 64'd14);
        step();

        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) step();
        reset = 1'b1;
        step();
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort hi", 64'(hi), 64'd0);
        chk("abort lo", 64'(lo), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        reset = 1'b0;
        run_op("divu94", 3'd3, 32'd9, 32'd4, 32'd1, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
